mgmt_drp_bridge: RTL and testbench
==================================

# mgmt_drp_bridge

Parametrised multi-lane DRP access bridge for the 8-bit management register bus (QSPI bridge / simulation bridge side, 16-bit byte addresses). It gives each of NUM_LANES transceiver DRP ports a staged write-data/address register set, a per-lane transaction state machine with completion timeout, captured read data, sticky status, and a maskable write-1-to-clear completion interrupt. It replaces the fixed two-lane, timeout-less DRP decode in the management register block.

## Interface
- NUM_LANES, 4: DRP lanes, 1..8.
- ADDR_BITS, 9: DRP address width, 1..15.
- TIMEOUT, 1023: cycles a transaction may stay busy before abort, ≥1.
- BASE_ADDR, 16'h0080: address of lane 0 register set.
- STRIDE, 16'h0020: address spacing between lane sets, ≥8.
- clk  in  1  management core clock.
- rst  in  1  synchronous active-high reset.
- rd_en  in  1  read strobe.
- rd_addr  in  16  read byte address.
- rd_valid  out  1  read data valid pulse.
- rd_data  out  8  read data.
- wr_en  in  1  write strobe.
- wr_addr  in  16  write byte address.
- wr_data  in  8  write data.
- irq  out  1  |(irq_stat & irq_mask), registered.
- drp_en  out  NUM_LANES  one-cycle DRP enable per lane.
- drp_we  out  1  shared write enable, valid with any drp_en.
- drp_addr  out  ADDR_BITS  shared address, valid with any drp_en.
- drp_wdata  out  16  shared write data, valid with any drp_en.
- drp_rdata  in  16*NUM_LANES  lane i at [16i+15:16i].
- drp_done  in  NUM_LANES  DRP ready pulse per lane.
- rx_rstdone  in  NUM_LANES  lane RX reset done, already in clk domain.

## Operation
- Lane i set at L = BASE_ADDR + i*STRIDE: L+0/L+1 WD low/high (RW); L+2 AD[7:0] (RW); L+3 launch (W): bit7 = we, bits[6:0] = AD[14:8] (bits ≥ ADDR_BITS dropped); L+4/L+5 RD low/high (R); L+6 STAT (R): bit0 busy, bit1 timeout, bit2 done, bit3 overrun, bit4 rx_rstdone; write any value to L+6 clears bits1-3.
- Global at G = BASE_ADDR + NUM_LANES*STRIDE: G+0 irq_stat (R, W1C), bit i = lane i completed or timed out; G+1 irq_mask (RW). Bits ≥ NUM_LANES read 0.
- Unmapped reads return 0; unmapped writes ignored.
- Per-lane FSM IDLE/BUSY. IDLE + launch write: pulse drp_en[i], drive drp_we/addr/wdata from that lane's staging, clear counter, enter BUSY. BUSY + drp_done[i]: capture drp_rdata lane into RD (only if we=0), set done, set irq_stat[i], go IDLE. BUSY + counter == TIMEOUT, no done: set timeout and done, set irq_stat[i], RD unchanged, go IDLE.
- Launch while BUSY: ignored, overrun set, no drp_en.
- drp_done while IDLE (late/spurious): ignored.
- Shared bus: values change only on a launch cycle; concurrent busy lanes legal since DRP samples on en.
- Only one launch per cycle possible (single write port).

## Timing
- Reset: all outputs 0, all FSMs IDLE, staging/RD/status/irq_stat/irq_mask 0, counters 0.
- Read: rd_en at cycle N -> rd_valid=1, rd_data at N+1, single cycle; back-to-back reads each answered.
- Launch write at N -> drp_en[i] high at N+1 only; STAT.busy reads 1 for reads issued from N+1.
- Counter increments each BUSY cycle from 0 at N+1; timeout at the edge where it equals TIMEOUT, i.e. busy for TIMEOUT+1 cycles.
- drp_done[i] at cycle M -> RD, STAT, irq_stat updated at M+1; irq at M+2.
- done and timeout same cycle: done wins (data captured, timeout stays 0).
- W1C of irq_stat[i] same cycle as lane i completion: set wins.
- STAT clear write same cycle as completion: completion flags win.
- Staging writes while BUSY allowed; affect next launch only.
- rst mid-transaction: lanes IDLE next cycle, no irq, later drp_done ignored.

## Test plan
- Read lane 2 addr 0x07C: write WD, AD=0x7C, launch 0x00; drp_done[2] after 5 cycles with rdata 0xBEEF -> RD=EF/BE, STAT=0x04|rstdone, irq_stat=0x04, irq=1 only after mask=0x04.
- Write lane 0: WD=0x1234, AD=0x123 with we -> single drp_en[0], drp_we=1, drp_addr=0x123, drp_wdata=0x1234; RD stays 0.
- TIMEOUT=16, no done -> busy exactly 17 cycles, then STAT timeout=1 done=1; drp_done one cycle later ignored.
- Relaunch lane 1 while busy -> no second drp_en, overrun=1; clear via STAT write -> 0x00 (plus rstdone).
- drp_done[3] same cycle as W1C 0x08 -> irq_stat bit3 remains 1; rst during BUSY -> all status 0, irq 0.

Source files
------------

// File: rtl/mgmt_drp_bridge_if.sv
// Byte-wide management register bus: strobed reads answered one cycle later,
// strobed writes applied at the next clock edge.
interface mgmt_drp_bridge_if;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  rd_valid, rd_data
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output rd_valid, rd_data
  );
endinterface

// File: rtl/mgmt_drp_bridge.sv
// Multi-lane DRP access bridge: per-lane staging registers, launch FSM with
// completion timeout, captured read data, sticky status and a W1C completion irq.
module mgmt_drp_bridge #(
  parameter int          NUM_LANES = 4,
  parameter int          ADDR_BITS = 9,
  parameter int          TIMEOUT   = 1023,
  parameter logic [15:0] BASE_ADDR = 16'h0080,
  parameter logic [15:0] STRIDE    = 16'h0020
) (
  input  logic                   clk,
  input  logic                   rst,
  mgmt_drp_bridge_if.slave       bus,
  output logic                   irq,
  output logic [NUM_LANES-1:0]   drp_en,
  output logic                   drp_we,
  output logic [ADDR_BITS-1:0]   drp_addr,
  output logic [15:0]            drp_wdata,
  input  logic [16*NUM_LANES-1:0] drp_rdata,
  input  logic [NUM_LANES-1:0]   drp_done,
  input  logic [NUM_LANES-1:0]   rx_rstdone
);

  localparam int          CW          = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_CNT    = CW'(TIMEOUT);
  localparam logic [15:0] GLOBAL_ADDR = 16'(BASE_ADDR + NUM_LANES * STRIDE);

  typedef enum logic {IDLE, BUSY} lane_state_t;

  lane_state_t          state_reg [NUM_LANES];
  logic [CW-1:0]        cnt_reg   [NUM_LANES];
  logic [15:0]          wd_reg    [NUM_LANES];
  logic [7:0]           ad_reg    [NUM_LANES];
  logic [15:0]          rd_reg    [NUM_LANES];
  logic                 we_reg    [NUM_LANES];
  logic [NUM_LANES-1:0] timeout_reg, done_reg, overrun_reg;
  logic [NUM_LANES-1:0] irq_stat_reg, irq_mask_reg, drp_en_reg;
  logic                 irq_reg, drp_we_reg, rd_valid_reg;
  logic [ADDR_BITS-1:0] drp_addr_reg;
  logic [15:0]          drp_wdata_reg;
  logic [7:0]           rd_data_reg;

  logic [NUM_LANES-1:0] sel_wd_lo, sel_wd_hi, sel_ad, sel_launch, sel_stat;
  logic [NUM_LANES-1:0] launch_ok, done_evt, to_evt, complete;
  logic [NUM_LANES-1:0][7:0] lane_rd;
  logic                 sel_irq_stat, sel_irq_mask;
  logic [7:0]           rd_next;
  logic                 launch_we;
  logic [14:0]          launch_ad;
  logic [15:0]          launch_wd;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      localparam logic [15:0] LANE_ADDR = 16'(BASE_ADDR + gi * STRIDE);
      logic [15:0] wr_off, rd_off;
      logic [7:0]  rd_val;
      logic        busy;

      assign wr_off = bus.wr_addr - LANE_ADDR;
      assign rd_off = bus.rd_addr - LANE_ADDR;
      assign busy   = (state_reg[gi] == BUSY);

      assign sel_wd_lo[gi]  = bus.wr_en && (wr_off == 16'd0);
      assign sel_wd_hi[gi]  = bus.wr_en && (wr_off == 16'd1);
      assign sel_ad[gi]     = bus.wr_en && (wr_off == 16'd2);
      assign sel_launch[gi] = bus.wr_en && (wr_off == 16'd3);
      assign sel_stat[gi]   = bus.wr_en && (wr_off == 16'd6);

      // drp_done has priority over an expiring counter in the same cycle
      assign launch_ok[gi] = sel_launch[gi] && !busy;
      assign done_evt[gi]  = busy && drp_done[gi];
      assign to_evt[gi]    = busy && !drp_done[gi] && (cnt_reg[gi] == TO_CNT);
      assign complete[gi]  = done_evt[gi] || to_evt[gi];

      always_comb begin
        rd_val = 8'h00;
        case (rd_off)
          16'd0:   rd_val = wd_reg[gi][7:0];
          16'd1:   rd_val = wd_reg[gi][15:8];
          16'd2:   rd_val = ad_reg[gi];
          16'd4:   rd_val = rd_reg[gi][7:0];
          16'd5:   rd_val = rd_reg[gi][15:8];
          16'd6:   rd_val = {3'b000, rx_rstdone[gi], overrun_reg[gi],
                             done_reg[gi], timeout_reg[gi], busy};
          default: rd_val = 8'h00;
        endcase
      end
      assign lane_rd[gi] = rd_val;
    end
  endgenerate

  assign sel_irq_stat = bus.wr_en && (bus.wr_addr == GLOBAL_ADDR);
  assign sel_irq_mask = bus.wr_en && (bus.wr_addr == GLOBAL_ADDR + 16'd1);

  always_comb begin
    rd_next = 8'h00;
    for (int i = 0; i < NUM_LANES; i++) rd_next = rd_next | lane_rd[i];
    if (bus.rd_addr == GLOBAL_ADDR)         rd_next = 8'(irq_stat_reg);
    if (bus.rd_addr == GLOBAL_ADDR + 16'd1) rd_next = 8'(irq_mask_reg);
  end

  // At most one lane can accept a launch per cycle: there is one write port
  always_comb begin
    launch_we = 1'b0;
    launch_ad = '0;
    launch_wd = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (launch_ok[i]) begin
        launch_we = bus.wr_data[7];
        launch_ad = {bus.wr_data[6:0], ad_reg[i]};
        launch_wd = wd_reg[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        state_reg[i] <= IDLE;
        cnt_reg[i]   <= '0;
        wd_reg[i]    <= '0;
        ad_reg[i]    <= '0;
        rd_reg[i]    <= '0;
        we_reg[i]    <= 1'b0;
      end
      timeout_reg   <= '0;
      done_reg      <= '0;
      overrun_reg   <= '0;
      irq_stat_reg  <= '0;
      irq_mask_reg  <= '0;
      drp_en_reg    <= '0;
      irq_reg       <= 1'b0;
      drp_we_reg    <= 1'b0;
      drp_addr_reg  <= '0;
      drp_wdata_reg <= '0;
      rd_valid_reg  <= 1'b0;
      rd_data_reg   <= '0;
    end else begin
      rd_valid_reg <= bus.rd_en;
      rd_data_reg  <= bus.rd_en ? rd_next : 8'h00;
      irq_reg      <= |(irq_stat_reg & irq_mask_reg);
      drp_en_reg   <= launch_ok;

      if (|launch_ok) begin
        drp_we_reg    <= launch_we;
        drp_addr_reg  <= launch_ad[ADDR_BITS-1:0];
        drp_wdata_reg <= launch_wd;
      end

      // Completion sets are applied after the W1C so a same-cycle set wins
      if (sel_irq_stat) irq_stat_reg <= (irq_stat_reg & ~bus.wr_data[NUM_LANES-1:0]) | complete;
      else              irq_stat_reg <= irq_stat_reg | complete;
      if (sel_irq_mask) irq_mask_reg <= bus.wr_data[NUM_LANES-1:0];

      for (int i = 0; i < NUM_LANES; i++) begin
        if (sel_wd_lo[i]) wd_reg[i][7:0]  <= bus.wr_data;
        if (sel_wd_hi[i]) wd_reg[i][15:8] <= bus.wr_data;
        if (sel_ad[i])    ad_reg[i]       <= bus.wr_data;
        if (sel_stat[i]) begin
          timeout_reg[i] <= 1'b0;
          done_reg[i]    <= 1'b0;
          overrun_reg[i] <= 1'b0;
        end
        if (sel_launch[i] && state_reg[i] == BUSY) overrun_reg[i] <= 1'b1;

        case (state_reg[i])
          IDLE: begin
            if (launch_ok[i]) begin
              state_reg[i] <= BUSY;
              cnt_reg[i]   <= '0;
              we_reg[i]    <= bus.wr_data[7];
            end
          end
          BUSY: begin
            cnt_reg[i] <= cnt_reg[i] + CW'(1);
            if (done_evt[i]) begin
              if (!we_reg[i]) rd_reg[i] <= drp_rdata[16*i +: 16];
              done_reg[i]  <= 1'b1;
              state_reg[i] <= IDLE;
            end else if (to_evt[i]) begin
              timeout_reg[i] <= 1'b1;
              done_reg[i]    <= 1'b1;
              state_reg[i]   <= IDLE;
            end
          end
          default: state_reg[i] <= IDLE;
        endcase
      end
    end
  end

  assign irq          = irq_reg;
  assign drp_en       = drp_en_reg;
  assign drp_we       = drp_we_reg;
  assign drp_addr     = drp_addr_reg;
  assign drp_wdata    = drp_wdata_reg;
  assign bus.rd_valid = rd_valid_reg;
  assign bus.rd_data  = rd_data_reg;

endmodule

// File: tb/tb_mgmt_drp_bridge.sv
// Bench for mgmt_drp_bridge: directed scenarios plus randomized traffic, all
// outputs compared every cycle against a transaction-level register model.
module tb_mgmt_drp_bridge;
  localparam int          NL    = 4;
  localparam int          AB    = 9;
  localparam int          TO    = 16;
  localparam logic [15:0] BASE  = 16'h0080;
  localparam logic [15:0] STR   = 16'h0020;
  localparam logic [15:0] GADDR = 16'(BASE + NL * STR);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mgmt_drp_bridge_if bus();
  logic              irq;
  logic [NL-1:0]     drp_en;
  logic              drp_we;
  logic [AB-1:0]     drp_addr;
  logic [15:0]       drp_wdata;
  logic [16*NL-1:0]  drp_rdata;
  logic [NL-1:0]     drp_done;
  logic [NL-1:0]     rx_rstdone;

  mgmt_drp_bridge #(
    .NUM_LANES(NL), .ADDR_BITS(AB), .TIMEOUT(TO), .BASE_ADDR(BASE), .STRIDE(STR)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .irq(irq),
    .drp_en(drp_en), .drp_we(drp_we), .drp_addr(drp_addr), .drp_wdata(drp_wdata),
    .drp_rdata(drp_rdata), .drp_done(drp_done), .rx_rstdone(rx_rstdone)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Register-level model of the bridge
  logic [15:0]   m_wd [NL];
  logic [7:0]    m_ad [NL];
  logic [15:0]   m_rd [NL];
  bit            m_busy [NL];
  bit            m_we [NL];
  int            m_start [NL];
  bit            m_to [NL];
  bit            m_done [NL];
  bit            m_ovr [NL];
  logic [NL-1:0] m_stat, m_mask;

  logic          e_rd_valid;
  logic [7:0]    e_rd_data;
  logic [15:0]   e_rd_addr;
  logic          e_irq;
  logic [NL-1:0] e_en;
  logic          e_we;
  logic [AB-1:0] e_addr;
  logic [15:0]   e_wdata;

  function automatic logic [15:0] la(input int lane, input int off);
    return 16'(int'(BASE) + lane * int'(STR) + off);
  endfunction

  function automatic logic [7:0] model_read(input logic [15:0] a);
    int rel, k, off;
    if (a == GADDR) return 8'(m_stat);
    if (a == GADDR + 16'd1) return 8'(m_mask);
    if (a < BASE) return 8'h00;
    rel = int'(a) - int'(BASE);
    k   = rel / int'(STR);
    off = rel % int'(STR);
    if (k >= NL) return 8'h00;
    case (off)
      0: return m_wd[k][7:0];
      1: return m_wd[k][15:8];
      2: return m_ad[k];
      4: return m_rd[k][7:0];
      5: return m_rd[k][15:8];
      6: return {3'b000, rx_rstdone[k], m_ovr[k], m_done[k], m_to[k], m_busy[k]};
      default: return 8'h00;
    endcase
  endfunction

  // Apply this cycle's inputs to the model; e_* become next cycle's outputs
  task automatic model_update();
    bit            old_busy [NL];
    logic [NL-1:0] fin;
    int            rel, k, off;
    bit            hit;
    if (rst) begin
      for (int i = 0; i < NL; i++) begin
        m_wd[i] = '0; m_ad[i] = '0; m_rd[i] = '0; m_busy[i] = 0; m_we[i] = 0;
        m_start[i] = 0; m_to[i] = 0; m_done[i] = 0; m_ovr[i] = 0;
      end
      m_stat = '0; m_mask = '0;
      e_rd_valid = 0; e_rd_data = '0; e_irq = 0; e_en = '0;
      e_we = 0; e_addr = '0; e_wdata = '0;
      return;
    end
    e_rd_valid = bus.rd_en;
    e_rd_addr  = bus.rd_addr;
    if (bus.rd_en) e_rd_data = model_read(bus.rd_addr);
    e_irq = |(m_stat & m_mask);
    e_en  = '0;
    fin   = '0;
    for (int i = 0; i < NL; i++) old_busy[i] = m_busy[i];
    hit = 0; k = 0; off = 0;
    if (bus.wr_en && bus.wr_addr >= BASE) begin
      rel = int'(bus.wr_addr) - int'(BASE);
      k   = rel / int'(STR);
      off = rel % int'(STR);
      hit = (k < NL) && (off <= 6);
    end
    if (bus.wr_en && bus.wr_addr == GADDR) m_stat = m_stat & ~bus.wr_data[NL-1:0];
    if (bus.wr_en && bus.wr_addr == GADDR + 16'd1) m_mask = bus.wr_data[NL-1:0];
    if (hit) begin
      case (off)
        0: m_wd[k][7:0]  = bus.wr_data;
        1: m_wd[k][15:8] = bus.wr_data;
        2: m_ad[k]       = bus.wr_data;
        6: begin m_to[k] = 0; m_done[k] = 0; m_ovr[k] = 0; end
        default: ;
      endcase
    end
    for (int i = 0; i < NL; i++) begin
      if (old_busy[i]) begin
        if (drp_done[i]) begin
          if (!m_we[i]) m_rd[i] = drp_rdata[16*i +: 16];
          m_done[i] = 1; m_busy[i] = 0; fin[i] = 1'b1;
        end else if (cyc - m_start[i] == TO) begin
          m_to[i] = 1; m_done[i] = 1; m_busy[i] = 0; fin[i] = 1'b1;
        end
      end
    end
    m_stat = m_stat | fin;
    if (hit && off == 3) begin
      if (old_busy[k]) m_ovr[k] = 1;
      else begin
        e_en[k]    = 1'b1;
        e_we       = bus.wr_data[7];
        e_addr     = AB'({bus.wr_data[6:0], m_ad[k]});
        e_wdata    = m_wd[k];
        m_busy[k]  = 1;
        m_we[k]    = bus.wr_data[7];
        m_start[k] = cyc + 1;
      end
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
    cyc++;
    check("rd_valid", bus.rd_valid, e_rd_valid);
    if (e_rd_valid) begin
      check("rd_data", bus.rd_data, e_rd_data);
      $display("cyc %0d rd 0x%04h -> 0x%02h", cyc, e_rd_addr, bus.rd_data);
    end
    if (|e_en) $display("cyc %0d launch en=%b we=%0b addr=0x%03h wdata=0x%04h", cyc, e_en, e_we, e_addr, e_wdata);
    check("drp_en", drp_en, e_en);
    check("drp_we", drp_we, e_we);
    check("drp_addr", drp_addr, e_addr);
    check("drp_wdata", drp_wdata, e_wdata);
    check("irq", irq, e_irq);
  endtask

  task automatic idle_inputs();
    rst = 1'b0;
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    drp_done = '0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    tick();
    idle_inputs();
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] d);
    bus.rd_en = 1'b1; bus.rd_addr = a;
    tick();
    d = bus.rd_data;
    idle_inputs();
  endtask

  function automatic logic [15:0] pick_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return la($urandom_range(0, NL-1), $urandom_range(0, 7));
    if (r < 9) return GADDR + 16'($urandom_range(0, 2));
    return 16'($urandom);
  endfunction

  int ofs_tbl [8] = '{0, 1, 2, 3, 3, 3, 6, 7};

  initial begin
    logic [7:0] v;
    int         busy_cnt;

    rst = 1'b1;
    bus.rd_en = 0; bus.rd_addr = '0; bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
    drp_rdata = '0; drp_done = '0; rx_rstdone = '0;
    tick();
    tick();
    idle_inputs();
    tick();

    // Lane 2 DRP read of address 0x07C
    rx_rstdone = 4'b0100;
    wr(la(2, 0), 8'h11);
    wr(la(2, 1), 8'h22);
    wr(la(2, 2), 8'h7C);
    wr(la(2, 3), 8'h00);
    check("tp1_en", drp_en, 4'b0100);
    check("tp1_addr", drp_addr, 9'h07C);
    for (int t = 0; t < 4; t++) tick();
    drp_rdata[32 +: 16] = 16'hBEEF;
    drp_done[2] = 1'b1;
    tick();
    idle_inputs();
    rd(la(2, 4), v);  check("tp1_rd_lo", v, 8'hEF);
    rd(la(2, 5), v);  check("tp1_rd_hi", v, 8'hBE);
    rd(la(2, 6), v);  check("tp1_stat", v, 8'h14);
    rd(GADDR, v);     check("tp1_irq_stat", v, 8'h04);
    check("tp1_irq_masked", irq, 1'b0);
    wr(GADDR + 16'd1, 8'h04);
    tick();
    check("tp1_irq", irq, 1'b1);
    wr(GADDR, 8'hFF);
    wr(GADDR + 16'd1, 8'h00);

    // Lane 0 DRP write
    wr(la(0, 0), 8'h34);
    wr(la(0, 1), 8'h12);
    wr(la(0, 2), 8'h23);
    wr(la(0, 3), 8'h81);
    check("tp2_en", drp_en, 4'b0001);
    check("tp2_we", drp_we, 1'b1);
    check("tp2_addr", drp_addr, 9'h123);
    check("tp2_wdata", drp_wdata, 16'h1234);
    tick();
    drp_rdata[0 +: 16] = 16'hAAAA;
    drp_done[0] = 1'b1;
    tick();
    idle_inputs();
    rd(la(0, 4), v);  check("tp2_rd_lo", v, 8'h00);
    rd(la(0, 5), v);  check("tp2_rd_hi", v, 8'h00);

    // Lane 1 timeout
    wr(la(1, 3), 8'h00);
    busy_cnt = 0;
    for (int t = 0; t < 40; t++) begin
      rd(la(1, 6), v);
      if (!v[0]) break;
      busy_cnt++;
    end
    check("tp3_busy_cycles", busy_cnt, TO + 1);
    check("tp3_stat", v, 8'h06);
    drp_rdata[16 +: 16] = 16'h5555;
    drp_done[1] = 1'b1;
    tick();
    idle_inputs();
    rd(la(1, 4), v);  check("tp3_rd_unchanged", v, 8'h00);
    rd(la(1, 6), v);  check("tp3_stat_after", v, 8'h06);

    // Lane 1 overrun, then clear
    wr(la(1, 6), 8'h00);
    wr(la(1, 3), 8'h00);
    wr(la(1, 3), 8'h00);
    check("tp4_no_second_en", drp_en, 4'b0000);
    rd(la(1, 6), v);  check("tp4_stat_ovr", v, 8'h09);
    drp_done[1] = 1'b1;
    tick();
    idle_inputs();
    wr(la(1, 6), 8'h00);
    rd(la(1, 6), v);  check("tp4_stat_clr", v, 8'h00);

    // Lane 3 completion collides with W1C of its irq bit
    wr(GADDR, 8'hFF);
    wr(la(3, 3), 8'h80);
    tick();
    drp_done[3] = 1'b1;
    bus.wr_en = 1'b1; bus.wr_addr = GADDR; bus.wr_data = 8'h08;
    tick();
    idle_inputs();
    rd(GADDR, v);     check("tp5_set_wins", v, 8'h08);

    // Reset while lane 0 is busy; a late drp_done must be ignored
    rx_rstdone = '0;
    wr(GADDR + 16'd1, 8'h0F);
    wr(la(0, 3), 8'h00);
    tick();
    rst = 1'b1;
    tick();
    idle_inputs();
    drp_done = '1;
    tick();
    idle_inputs();
    for (int i = 0; i < NL; i++) begin
      rd(la(i, 6), v);
      check($sformatf("tp6_stat%0d", i), v, 8'h00);
    end
    rd(GADDR, v);     check("tp6_irq_stat", v, 8'h00);
    check("tp6_irq", irq, 1'b0);

    // Randomized traffic
    for (int t = 0; t < 1200; t++) begin
      idle_inputs();
      if ($urandom_range(0, 99) < 30) begin
        bus.wr_en = 1'b1;
        if ($urandom_range(0, 9) < 8) bus.wr_addr = la($urandom_range(0, NL-1), ofs_tbl[$urandom_range(0, 7)]);
        else                           bus.wr_addr = pick_addr();
        bus.wr_data = 8'($urandom);
      end
      bus.rd_en   = ($urandom_range(0, 99) < 40);
      bus.rd_addr = pick_addr();
      for (int i = 0; i < NL; i++) begin
        drp_done[i] = ($urandom_range(0, 99) < 4);
        drp_rdata[16*i +: 16] = 16'($urandom);
      end
      if ($urandom_range(0, 49) == 0) rx_rstdone = NL'($urandom);
      rst = ($urandom_range(0, 599) == 0);
      tick();
    end
    idle_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
